// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// The default mode is 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  // One complete raster mode: horizontal and vertical active/porch/sync sizes.
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  localparam int DEF_XW = 10;
  localparam int DEF_YW = 10;
  localparam int DEF_FW = 8;

  // Full period of one axis, counted in ticks of that axis.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter with registered active and sync decodes.
// The decodes are computed from the next count, so they line up with count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         in_active,
  output logic         sync_out,
  output logic         wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // The counter must hold TOTAL-1 without overflowing.
  if (TOTAL > (1 << W)) begin : g_width_check
    $error("vga_axis_counter: W too small for axis total");
  end

  // The end bounds are one bit wider, since they may equal 2^W.
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W:0]   SYNC_END   = (W+1)'(ACTIVE + FP + SYNC);
  localparam logic [W:0]   ACT_END    = (W+1)'(ACTIVE);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;
  logic         in_active_reg;
  logic         sync_reg;
  logic         last;

  assign last = (count_reg == LAST);

  // Next count: advance on step, wrap after the last tick of the period.
  always_comb begin
    count_next = count_reg;
    if (step) begin
      count_next = last ? '0 : count_reg + 1'b1;
    end
  end

  // The wrap strobe is suppressed during reset so it cannot fire while restarting.
  assign wrap = step & ~rst & last;

  // Count and decodes update together, with no latency between them.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg     <= '0;
      in_active_reg <= 1'b1;
      sync_reg      <= ~POL;
    end else begin
      count_reg     <= count_next;
      in_active_reg <= ({1'b0, count_next} < ACT_END);
      sync_reg      <= ((count_next >= SYNC_START) && ({1'b0, count_next} < SYNC_END))
                       ? POL : ~POL;
    end
  end

  assign count     = count_reg;
  assign in_active = in_active_reg;
  assign sync_out  = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: coordinates, active flag, syncs
// and line/frame strobes. The frame counter output exists only when
// VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_640X480.h_active,
  parameter int H_FP     = MODE_640X480.h_fp,
  parameter int H_SYNC   = MODE_640X480.h_sync,
  parameter int H_BP     = MODE_640X480.h_bp,
  parameter int V_ACTIVE = MODE_640X480.v_active,
  parameter int V_FP     = MODE_640X480.v_fp,
  parameter int V_SYNC   = MODE_640X480.v_sync,
  parameter int V_BP     = MODE_640X480.v_bp,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int FW       = DEF_FW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          new_line,
  output logic          new_frame
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FW-1:0] frame
`endif
);

  if (FW < 1) begin : g_fw_check
    $error("vga_timing_gen: FW must be at least 1");
  end

  logic h_active;
  logic v_active;
  logic h_wrap;
  logic v_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HS_POL), .W(XW)
  ) u_h (
    .clk      (clk),
    .rst      (rst),
    .step     (en),
    .count    (x),
    .in_active(h_active),
    .sync_out (hsync),
    .wrap     (h_wrap)
  );

  // Rows advance once per completed line, so vsync is line-aligned.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VS_POL), .W(YW)
  ) u_v (
    .clk      (clk),
    .rst      (rst),
    .step     (h_wrap),
    .count    (y),
    .in_active(v_active),
    .sync_out (vsync),
    .wrap     (v_wrap)
  );

  assign active    = h_active & v_active;
  assign new_line  = h_wrap;
  assign new_frame = v_wrap;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FW-1:0] frame_reg;

  // Frame counter advances on every frame wrap and rolls over modulo 2^FW.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_reg <= '0;
    end else if (v_wrap) begin
      frame_reg <= frame_reg + 1'b1;
    end
  end

  assign frame = frame_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in a small 15x7 mode
// (H 8/2/3/2, V 4/1/1/1), with one active-low and one active-high instance.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] x, x_p;
  logic [3:0] y, y_p;
  logic       active, active_p;
  logic       hsync, hsync_p;
  logic       vsync, vsync_p;
  logic       new_line, new_line_p;
  logic       new_frame, new_frame_p;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [1:0] frame, frame_p;
`endif

  int checks   = 0;
  int failures = 0;
  int ex = 0;
  int ey = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .XW(4), .YW(4), .FW(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .active(active),
    .hsync(hsync), .vsync(vsync), .new_line(new_line), .new_frame(new_frame)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame(frame)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .XW(4), .YW(4), .FW(2)
  ) dut_p (
    .clk(clk), .rst(rst), .en(en), .x(x_p), .y(y_p), .active(active_p),
    .hsync(hsync_p), .vsync(vsync_p), .new_line(new_line_p), .new_frame(new_frame_p)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame(frame_p)
`endif
  );

  // One clock edge; the expected position follows rst/en, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ex = 0;
      ey = 0;
    end else if (en) begin
      if (ex == 14) begin
        ex = 0;
        ey = (ey == 6) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) tick();
    checks++; if (x !== 4'd0 || y !== 4'd0) begin failures++; $display("FAIL reset_xy x=%0d y=%0d want 0,0", x, y); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL reset_active got %b want 1", active); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin failures++; $display("FAIL reset_sync hs=%b vs=%b want 1,1", hsync, vsync); end
    checks++; if (hsync_p !== 1'b0 || vsync_p !== 1'b0) begin failures++; $display("FAIL reset_sync_pol hs=%b vs=%b want 0,0", hsync_p, vsync_p); end
    checks++; if (new_line !== 1'b0 || new_frame !== 1'b0) begin failures++; $display("FAIL reset_strobe nl=%b nf=%b want 0,0", new_line, new_frame); end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++; if (frame !== 2'd0) begin failures++; $display("FAIL reset_frame got %0d want 0", frame); end
`endif
    $display("test_reset done checks=%0d", checks);
  endtask

  // Two full frames with en held high; every output checked on every cycle.
  task automatic test_counting();
    int nl_cnt = 0;
    int nf_cnt = 0;
    logic e_line, e_frame, e_act, e_hs, e_vs;
    rst = 1'b0;
    en  = 1'b1;
    for (int c = 0; c < 210; c++) begin
      e_line  = (ex == 14);
      e_frame = (ex == 14) && (ey == 6);
      e_act   = (ex < 8) && (ey < 4);
      e_hs    = !((ex >= 10) && (ex <= 12));
      e_vs    = (ey != 5);
      if (new_line)  nl_cnt++;
      if (new_frame) nf_cnt++;
      checks++; if (x !== ex[3:0] || y !== ey[3:0]) begin failures++; $display("FAIL count_xy c=%0d x=%0d y=%0d want %0d,%0d", c, x, y, ex, ey); end
      checks++; if (new_line !== e_line || new_frame !== e_frame) begin failures++; $display("FAIL count_strobe c=%0d nl=%b nf=%b want %b,%b", c, new_line, new_frame, e_line, e_frame); end
      checks++; if (active !== e_act) begin failures++; $display("FAIL count_active c=%0d got %b want %b", c, active, e_act); end
      checks++; if (hsync !== e_hs || vsync !== e_vs) begin failures++; $display("FAIL count_sync c=%0d hs=%b vs=%b want %b,%b", c, hsync, vsync, e_hs, e_vs); end
      checks++; if (hsync_p !== !e_hs || vsync_p !== !e_vs) begin failures++; $display("FAIL count_sync_pol c=%0d hs=%b vs=%b want %b,%b", c, hsync_p, vsync_p, !e_hs, !e_vs); end
      tick();
    end
    checks++; if (nl_cnt != 14 || nf_cnt != 2) begin failures++; $display("FAIL strobe_totals lines=%0d frames=%0d want 14,2", nl_cnt, nf_cnt); end
    $display("test_counting done checks=%0d", checks);
  endtask

  // en pattern 1,0,0,1: position advances only on enabled edges.
  task automatic test_en_toggle();
    logic e_line;
    for (int c = 0; c < 48; c++) begin
      en = (c % 4 == 0) || (c % 4 == 3);
      #1;
      e_line = en && (ex == 14);
      checks++; if (new_line !== e_line || new_frame !== (e_line && ey == 6)) begin failures++; $display("FAIL en_strobe c=%0d en=%b nl=%b nf=%b want nl=%b", c, en, new_line, new_frame, e_line); end
      tick();
      checks++; if (x !== ex[3:0] || y !== ey[3:0]) begin failures++; $display("FAIL en_xy c=%0d x=%0d y=%0d want %0d,%0d", c, x, y, ex, ey); end
    end
    en = 1'b1;
    $display("test_en_toggle done checks=%0d", checks);
  endtask

  // Reset at (6,2) and at the line wrap tick: back to origin with no strobe.
  task automatic test_rst_mid();
    int guard = 0;
    en = 1'b1;
    while (!(ex == 6 && ey == 2) && guard < 200) begin tick(); guard++; end
    checks++; if (guard >= 200) begin failures++; $display("FAIL rst_reach x=%0d y=%0d want 6,2", x, y); end
    checks++; if (x !== 4'd6 || y !== 4'd2) begin failures++; $display("FAIL rst_pre x=%0d y=%0d want 6,2", x, y); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (x !== 4'd0 || y !== 4'd0) begin failures++; $display("FAIL rst_mid_xy x=%0d y=%0d want 0,0", x, y); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || hsync_p !== 1'b0 || vsync_p !== 1'b0) begin failures++; $display("FAIL rst_mid_sync hs=%b vs=%b hsp=%b vsp=%b want 1,1,0,0", hsync, vsync, hsync_p, vsync_p); end
    checks++; if (new_line !== 1'b0 || new_frame !== 1'b0) begin failures++; $display("FAIL rst_mid_strobe nl=%b nf=%b want 0,0", new_line, new_frame); end
    for (int c = 0; c < 14; c++) tick();
    checks++; if (x !== 4'd14 || y !== 4'd0 || hsync !== 1'b1) begin failures++; $display("FAIL rst_resume x=%0d y=%0d hs=%b want 14,0,1", x, y, hsync); end
    checks++; if (new_line !== 1'b1) begin failures++; $display("FAIL rst_resume_line got %b want 1", new_line); end
    rst = 1'b1;
    #1;
    checks++; if (new_line !== 1'b0 || new_frame !== 1'b0) begin failures++; $display("FAIL rst_wrap_strobe nl=%b nf=%b want 0,0", new_line, new_frame); end
    tick();
    rst = 1'b0;
    checks++; if (x !== 4'd0 || y !== 4'd0) begin failures++; $display("FAIL rst_wrap_xy x=%0d y=%0d want 0,0", x, y); end
    $display("test_rst_mid done checks=%0d", checks);
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  // FW=2 frame counter across five frame starts, then cleared by reset mid-frame.
  task automatic test_frame();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (frame !== 2'(k % 4) || frame_p !== 2'(k % 4)) begin failures++; $display("FAIL frame_count k=%0d got %0d want %0d", k, frame, k % 4); end
      if (k < 4) repeat (105) tick();
    end
    repeat (155) tick();
    checks++; if (frame !== 2'd1) begin failures++; $display("FAIL frame_mid got %0d want 1", frame); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (frame !== 2'd0 || x !== 4'd0) begin failures++; $display("FAIL frame_rst frame=%0d x=%0d want 0,0", frame, x); end
    $display("test_frame done checks=%0d", checks);
  endtask
`endif

  initial begin
    test_reset();
    test_counting();
    test_en_toggle();
    test_rst_mid();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
